// File: rtl/tone_sequencer.sv
// Tone sequencer: plays a 16-entry note table (period, duration) with octave transposition.
// Optional macro TONE_SEQ_LOOP_EN: wrap back to entry 0 at end of table instead of finishing.
module tone_sequencer #(
    parameter int unsigned TICK_DIV = 24000,
    parameter int unsigned PW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          stop,
    input  logic          uptone,
    input  logic          downtone,
    input  logic          wr_en,
    input  logic [3:0]    wr_addr,
    input  logic [PW-1:0] wr_period,
    input  logic [7:0]    wr_dur,
    output logic [PW-1:0] tone_period,
    output logic          tone_on,
    output logic          busy,
    output logic          done,
    output logic [3:0]    cur_idx
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

    state_t            state_q;
    logic [PW-1:0]     period_q;
    logic [7:0]        dur_q;
    logic [7:0]        dcnt_q;
    logic [TW-1:0]     tick_q;
    logic [3:0]        idx_q;
    logic [2:0]        oct_q;
    logic [2:0]        oct_d;
    logic [PW+1:0]     shl;
    logic              tick_last;

    logic [PW-1:0]     tbl_period [16];
    logic [7:0]        tbl_dur    [16];

    // Note table is deliberately not reset so a loaded tune survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_period[wr_addr] <= wr_period;
            tbl_dur[wr_addr]    <= wr_dur;
        end
    end

    assign tick_last = (tick_q == TW'(TICK_DIV - 1));

    // Octave offset is two's complement, clamped to -2..+2.
    always_comb begin
        oct_d = oct_q;
        if (uptone && !downtone && oct_q != 3'b010)
            oct_d = oct_q + 3'd1;
        else if (downtone && !uptone && oct_q != 3'b110)
            oct_d = oct_q - 3'd1;
    end

    always_comb begin
        tone_period = period_q;
        shl         = '0;
        case (oct_q)
            3'b001: tone_period = period_q >> 1;
            3'b010: tone_period = period_q >> 2;
            3'b111: begin
                shl         = {2'b00, period_q} << 1;
                tone_period = (shl[PW+1:PW] != 2'b00) ? '1 : shl[PW-1:0];
            end
            3'b110: begin
                shl         = {2'b00, period_q} << 2;
                tone_period = (shl[PW+1:PW] != 2'b00) ? '1 : shl[PW-1:0];
            end
            default: tone_period = period_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            oct_q    <= '0;
            period_q <= '0;
            dur_q    <= '0;
            dcnt_q   <= '0;
            tick_q   <= '0;
        end else begin
            oct_q <= oct_d;
            if (stop && state_q != S_IDLE) begin
                state_q <= S_IDLE;
            end else if (en) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            idx_q   <= '0;
                            state_q <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (tbl_dur[idx_q] == 8'd0) begin
`ifdef TONE_SEQ_LOOP_EN
                            if (idx_q != 4'd0) begin
                                idx_q   <= '0;
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_DONE;
                            end
`else
                            state_q <= S_DONE;
`endif
                        end else begin
                            period_q <= tbl_period[idx_q];
                            dur_q    <= tbl_dur[idx_q];
                            tick_q   <= '0;
                            dcnt_q   <= '0;
                            state_q  <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (tick_last) begin
                            tick_q <= '0;
                            if (dcnt_q == dur_q - 8'd1) begin
                                dcnt_q  <= '0;
                                state_q <= S_GAP;
                            end else begin
                                dcnt_q <= dcnt_q + 8'd1;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    S_GAP: begin
                        if (tick_last) begin
                            tick_q <= '0;
                            if (idx_q == 4'd15) begin
`ifdef TONE_SEQ_LOOP_EN
                                idx_q   <= '0;
                                state_q <= S_LOAD;
`else
                                state_q <= S_DONE;
`endif
                            end else begin
                                idx_q   <= idx_q + 4'd1;
                                state_q <= S_LOAD;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign tone_on = en && (state_q == S_PLAY) && (period_q != '0);
    assign cur_idx = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer (TICK_DIV=4): per-cycle expectations are queued
// as stimulus is applied and compared one entry per clock.
module tb_tone_sequencer;

    localparam int unsigned TD = 4;
    localparam int unsigned PW = 16;

    logic          clk;
    logic          rst;
    logic          en;
    logic          start;
    logic          stop;
    logic          uptone;
    logic          downtone;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [PW-1:0] wr_period;
    logic [7:0]    wr_dur;
    logic [PW-1:0] tone_period;
    logic          tone_on;
    logic          busy;
    logic          done;
    logic [3:0]    cur_idx;

    tone_sequencer #(.TICK_DIV(TD), .PW(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .uptone(uptone), .downtone(downtone),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period), .wr_dur(wr_dur),
        .tone_period(tone_period), .tone_on(tone_on), .busy(busy), .done(done),
        .cur_idx(cur_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        tone;
        logic        done;
        logic [3:0]  idx;
        bit          chkp;
        logic [15:0] per;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int n, input logic b, input logic t, input logic d,
                        input logic [3:0] idx, input bit cp, input logic [15:0] p);
        exp_t e;
        e.busy = b; e.tone = t; e.done = d; e.idx = idx; e.chkp = cp; e.per = p;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic push_idle(input int n, input logic [3:0] idx);
        push(n, 1'b0, 1'b0, 1'b0, idx, 1'b0, 16'h0);
    endtask
    task automatic push_load(input logic [3:0] idx);
        push(1, 1'b1, 1'b0, 1'b0, idx, 1'b0, 16'h0);
    endtask
    task automatic push_play(input int n, input logic [3:0] idx, input logic [15:0] p);
        push(n, 1'b1, (p != 16'h0), 1'b0, idx, 1'b1, p);
    endtask
    task automatic push_gap(input int n, input logic [3:0] idx);
        push(n, 1'b1, 1'b0, 1'b0, idx, 1'b0, 16'h0);
    endtask
    task automatic push_done(input logic [3:0] idx);
        push(1, 1'b1, 1'b0, 1'b1, idx, 1'b0, 16'h0);
    endtask

    task automatic advance(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() == 0) begin
                check($sformatf("sb_empty c%0d", cyc), 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("busy c%0d", cyc), {31'd0, busy}, {31'd0, e.busy});
                check($sformatf("tone_on c%0d", cyc), {31'd0, tone_on}, {31'd0, e.tone});
                check($sformatf("done c%0d", cyc), {31'd0, done}, {31'd0, e.done});
                check($sformatf("cur_idx c%0d", cyc), {28'd0, cur_idx}, {28'd0, e.idx});
                if (e.chkp)
                    check($sformatf("tone_period c%0d", cyc), {16'd0, tone_period}, {16'd0, e.per});
            end
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] p, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_period = p; wr_dur = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        push_load(4'd0);
        advance(1);
        start = 1'b0;
    endtask

    task automatic pulse_oct(input logic u, input logic d, input logic [3:0] idx, input logic [15:0] p);
        uptone = u; downtone = d;
        push_play(1, idx, p);
        advance(1);
        uptone = 1'b0; downtone = 1'b0;
    endtask

    task automatic do_stop(input logic [3:0] idx);
        stop = 1'b1;
        push_idle(1, idx);
        advance(1);
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0;
        uptone = 1'b0; downtone = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;

        // reset state
        push(2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0);
        advance(2);
        rst = 1'b0;

        // basic tune: note, rest, end marker
        wr(4'd0, 16'd100, 8'd2);
        wr(4'd1, 16'd0, 8'd1);
        wr(4'd2, 16'd50, 8'd0);
        do_start();
        push_play(8, 4'd0, 16'd100);
        push_gap(4, 4'd0);
        push_load(4'd1);
        push_play(4, 4'd1, 16'd0);
        push_gap(4, 4'd1);
        push_load(4'd2);
`ifdef TONE_SEQ_LOOP_EN
        push_load(4'd0);
        push_play(2, 4'd0, 16'd100);
        advance(sb.size());
        do_stop(4'd0);
`else
        push_done(4'd2);
        push_idle(2, 4'd2);
        advance(sb.size());
`endif

        // enable hold mid-note lengthens it by the hold time
        do_start();
        push_play(3, 4'd0, 16'd100);
        advance(3);
        en = 1'b0;
        push_gap(10, 4'd0);
        advance(10);
        en = 1'b1;
        push_play(5, 4'd0, 16'd100);
        push_gap(4, 4'd0);
        push_load(4'd1);
        advance(10);
        do_stop(4'd1);

        // octave up/down with clamping, start ignored while busy, stop without done
        wr(4'd0, 16'd100, 8'd8);
        wr(4'd1, 16'd0, 8'd0);
        do_start();
        push_play(2, 4'd0, 16'd100);
        advance(2);
        start = 1'b1;
        push_play(1, 4'd0, 16'd100);
        advance(1);
        start = 1'b0;
        pulse_oct(1'b1, 1'b0, 4'd0, 16'd50);
        pulse_oct(1'b1, 1'b0, 4'd0, 16'd25);
        pulse_oct(1'b1, 1'b0, 4'd0, 16'd25);
        pulse_oct(1'b0, 1'b1, 4'd0, 16'd50);
        pulse_oct(1'b0, 1'b1, 4'd0, 16'd100);
        pulse_oct(1'b0, 1'b1, 4'd0, 16'd200);
        pulse_oct(1'b0, 1'b1, 4'd0, 16'd400);
        do_stop(4'd0);
        push_idle(2, 4'd0);
        advance(2);

        // back to octave 0 while idle, then saturation on down-shift
        uptone = 1'b1;
        push_idle(2, 4'd0);
        advance(2);
        uptone = 1'b0;
        wr(4'd0, 16'hC000, 8'd8);
        do_start();
        push_play(1, 4'd0, 16'hC000);
        advance(1);
        pulse_oct(1'b0, 1'b1, 4'd0, 16'hFFFF);
        pulse_oct(1'b0, 1'b1, 4'd0, 16'hFFFF);
        pulse_oct(1'b1, 1'b1, 4'd0, 16'hFFFF);
        pulse_oct(1'b1, 1'b0, 4'd0, 16'hFFFF);
        pulse_oct(1'b1, 1'b0, 4'd0, 16'hC000);
        pulse_oct(1'b1, 1'b0, 4'd0, 16'h6000);

        // reset mid-note overrides everything and clears octave
        rst = 1'b1; start = 1'b1; uptone = 1'b1;
        push(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0);
        advance(1);
        rst = 1'b0; start = 1'b0; uptone = 1'b0;
        push(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0);
        advance(1);

        // write to the playing entry only affects its next load
        wr(4'd0, 16'd100, 8'd1);
        wr(4'd1, 16'd0, 8'd0);
        do_start();
        push_play(1, 4'd0, 16'd100);
        advance(1);
        wr_en = 1'b1; wr_addr = 4'd0; wr_period = 16'd200; wr_dur = 8'd1;
        push_play(1, 4'd0, 16'd100);
        advance(1);
        wr_en = 1'b0;
        push_play(2, 4'd0, 16'd100);
        push_gap(4, 4'd0);
        push_load(4'd1);
`ifdef TONE_SEQ_LOOP_EN
        push_load(4'd0);
        push_play(4, 4'd0, 16'd200);
        advance(sb.size());
        do_stop(4'd0);
`else
        push_done(4'd1);
        push_idle(1, 4'd1);
        advance(sb.size());
        do_start();
        push_play(4, 4'd0, 16'd200);
        push_gap(4, 4'd0);
        push_load(4'd1);
        push_done(4'd1);
        push_idle(1, 4'd1);
        advance(sb.size());
`endif

        // full 16-entry table: end after index 15
        for (int i = 0; i < 16; i++) wr(4'(i), 16'(10 + i), 8'd1);
        do_start();
        for (int i = 0; i < 16; i++) begin
            push_play(4, 4'(i), 16'(10 + i));
            push_gap(4, 4'(i));
            if (i < 15) push_load(4'(i + 1));
        end
`ifdef TONE_SEQ_LOOP_EN
        push_load(4'd0);
        push_play(4, 4'd0, 16'd10);
        advance(sb.size());
        do_stop(4'd0);

        // looping two-note tune never pulses done
        wr(4'd0, 16'd100, 8'd1);
        wr(4'd1, 16'd50, 8'd1);
        wr(4'd2, 16'd0, 8'd0);
        do_start();
        for (int r = 0; r < 2; r++) begin
            push_play(4, 4'd0, 16'd100);
            push_gap(4, 4'd0);
            push_load(4'd1);
            push_play(4, 4'd1, 16'd50);
            push_gap(4, 4'd1);
            push_load(4'd2);
            push_load(4'd0);
        end
        advance(sb.size());
        do_stop(4'd0);
`else
        push_done(4'd15);
        push_idle(2, 4'd15);
        advance(sb.size());
`endif

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
